burst_memory_slave: RTL and testbench

Word-addressed on-chip burst memory that sits directly downstream of the master-memory port of the user logic and answers its burst reads and writes. It accepts one burst at a time on the split address/data handshake channels (aw/w/ar/r) and returns read data with `rlast` on the final beat. It is the memory the user-logic accumulate loop reads from in block-level and system simulation, and it is synthesizable as a small BRAM-backed buffer.

---
 rtl/burst_memory_slave_pkg.sv | 20 ++
 rtl/burst_memory_slave_if.sv | 35 +++
 rtl/burst_memory_slave_ram.sv | 43 ++++
 rtl/burst_memory_slave.sv | 199 +++++++++++++++++++
 tb/tb_burst_memory_slave.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/burst_memory_slave_pkg.sv
// Shared types and constants for the burst memory slave.
// The optional error checker is selected by BURST_MEMORY_SLAVE_ERR_EN in the top.
package burst_memory_slave_pkg;

    localparam int LEN_W = 8;

    typedef logic [LEN_W-1:0] len_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_e;

    // Number of byte-offset bits dropped from a byte address to form a word index
    function automatic int byte_off_w(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/burst_memory_slave_if.sv
// Split address/data burst channels (aw/w/ar/r) between a master and the burst memory.
interface burst_memory_slave_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    awvalid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic                    arvalid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awvalid, awaddr, awlen, wdata, wstrb, wlast, wvalid,
        output arvalid, araddr, arlen, rready,
        input  awready, wready, arready, rdata, rlast, rvalid
    );

    modport slave (
        input  awvalid, awaddr, awlen, wdata, wstrb, wlast, wvalid,
        input  arvalid, araddr, arlen, rready,
        output awready, wready, arready, rdata, rlast, rvalid
    );
endinterface

// File: rtl/burst_memory_slave_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module burst_memory_slave_ram #(
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      we,
    input  logic [DATA_WIDTH/8-1:0]   be,
    input  logic [MEM_ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0]     wdata,
    output logic [DATA_WIDTH-1:0]     rdata
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int DEPTH  = 2 ** MEM_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Byte-lane writes; array contents are deliberately not reset
    always_ff @(posedge clk) begin
        for (int b = 0; b < STRB_W; b++) begin
            if (en && we && be[b]) begin
                mem_q[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // Output register only updates on a read so stalled data stays put
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (en && !we) begin
            rdata_q <= mem_q[addr];
        end else begin
            rdata_q <= rdata_q;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/burst_memory_slave.sv
// Word-addressed burst memory answering one aw/w or ar/r burst at a time.
// Define BURST_MEMORY_SLAVE_ERR_EN to add the sticky err output and its checks.
module burst_memory_slave
    import burst_memory_slave_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    burst_memory_slave_if.slave  bus
`ifdef BURST_MEMORY_SLAVE_ERR_EN
    ,
    output logic                 err
`endif
);
    localparam int OFF_W = byte_off_w(DATA_WIDTH);

    typedef logic [MEM_ADDR_WIDTH-1:0] idx_t;
    localparam idx_t IDX_ONE = idx_t'(1'b1);

    state_e state_q, state_d;
    idx_t   idx_q, idx_d;
    len_t   len_q, len_d;
    len_t   cnt_q, cnt_d;
    logic   rvalid_q, rvalid_d;
    logic   rlast_q, rlast_d;

    idx_t                  aw_idx_s, ar_idx_s, ram_addr_s;
    logic                  aw_hs_s, ar_hs_s, w_hs_s, r_hs_s;
    logic                  ram_en_s, ram_we_s;
    logic [DATA_WIDTH-1:0] ram_rdata_s;

    assign aw_idx_s = bus.awaddr[OFF_W +: MEM_ADDR_WIDTH];
    assign ar_idx_s = bus.araddr[OFF_W +: MEM_ADDR_WIDTH];

    // A simultaneous write request blocks the read request
    assign bus.awready = (state_q == ST_IDLE);
    assign bus.arready = (state_q == ST_IDLE) && !bus.awvalid;
    assign bus.wready  = (state_q == ST_WRITE);

    assign aw_hs_s = bus.awvalid && bus.awready;
    assign ar_hs_s = bus.arvalid && bus.arready;
    assign w_hs_s  = bus.wvalid && bus.wready;
    assign r_hs_s  = rvalid_q && bus.rready;

    // Burst sequencing and RAM port steering
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        rvalid_d   = rvalid_q;
        rlast_d    = rlast_q;
        ram_en_s   = 1'b0;
        ram_we_s   = 1'b0;
        ram_addr_s = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (aw_hs_s) begin
                    state_d = ST_WRITE;
                    idx_d   = aw_idx_s;
                    len_d   = bus.awlen;
                    cnt_d   = '0;
                end else if (ar_hs_s) begin
                    // First word is fetched on the handshake cycle; idx then points one ahead
                    state_d    = ST_READ;
                    ram_en_s   = 1'b1;
                    ram_addr_s = ar_idx_s;
                    idx_d      = ar_idx_s + IDX_ONE;
                    len_d      = bus.arlen;
                    cnt_d      = '0;
                    rvalid_d   = 1'b1;
                    rlast_d    = (bus.arlen == 8'd0);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (w_hs_s) begin
                    ram_en_s = 1'b1;
                    ram_we_s = 1'b1;
                    idx_d    = idx_q + IDX_ONE;
                    if (cnt_q == len_q) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_READ: begin
                if (r_hs_s) begin
                    if (rlast_q) begin
                        state_d  = ST_IDLE;
                        rvalid_d = 1'b0;
                        rlast_d  = 1'b0;
                        cnt_d    = '0;
                    end else begin
                        ram_en_s = 1'b1;
                        idx_d    = idx_q + IDX_ONE;
                        cnt_d    = cnt_q + 8'd1;
                        rlast_d  = ((cnt_q + 8'd1) == len_q);
                    end
                end else begin
                    state_d = ST_READ;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                rvalid_d = 1'b0;
                rlast_d  = 1'b0;
                cnt_d    = '0;
            end
        endcase
    end

    // Control state registers
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            rlast_q  <= rlast_d;
        end
    end

    burst_memory_slave_ram #(
        .DATA_WIDTH     (DATA_WIDTH),
        .MEM_ADDR_WIDTH (MEM_ADDR_WIDTH)
    ) u_ram (
        .clk   (CLK),
        .rst_n (RST_N),
        .en    (ram_en_s),
        .we    (ram_we_s),
        .be    (bus.wstrb),
        .addr  (ram_addr_s),
        .wdata (bus.wdata),
        .rdata (ram_rdata_s)
    );

    assign bus.rdata  = ram_rdata_s;
    assign bus.rvalid = rvalid_q;
    assign bus.rlast  = rlast_q;

`ifdef BURST_MEMORY_SLAVE_ERR_EN
    typedef logic [MEM_ADDR_WIDTH:0] span_t;

    span_t aw_span_s, ar_span_s;
    logic  wlast_bad_s;
    logic  err_q, err_d;
    logic  unused_addr_s;

    // The carry bit flags a burst that runs past the last word
    assign aw_span_s   = span_t'(aw_idx_s) + span_t'(bus.awlen);
    assign ar_span_s   = span_t'(ar_idx_s) + span_t'(bus.arlen);
    assign wlast_bad_s = w_hs_s && (bus.wlast != (cnt_q == len_q));

    // Sticky error accumulation
    always_comb begin
        err_d = err_q;
        if ((aw_hs_s && aw_span_s[MEM_ADDR_WIDTH]) ||
            (ar_hs_s && ar_span_s[MEM_ADDR_WIDTH]) ||
            wlast_bad_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Error flag register
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err           = err_q;
    assign unused_addr_s = ^{bus.awaddr, bus.araddr};
`else
    logic unused_addr_s;
    assign unused_addr_s = ^{bus.awaddr, bus.araddr, bus.wlast};
`endif

endmodule

// File: tb/tb_burst_memory_slave.sv
// Directed bench for burst_memory_slave: reference memory model plus read scoreboard.
module tb_burst_memory_slave;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    burst_memory_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

`ifdef BURST_MEMORY_SLAVE_ERR_EN
    logic err;
`endif

    burst_memory_slave #(
        .DATA_WIDTH     (32),
        .ADDR_WIDTH     (32),
        .MEM_ADDR_WIDTH (10)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
`ifdef BURST_MEMORY_SLAVE_ERR_EN
        ,
        .err   (err)
`endif
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] model [0:1023];
    exp_t        sb_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic aw_req(input int word, input int len);
        int n;
        n = 0;
        bus.awvalid = 1'b1;
        bus.awaddr  = 32'(word * 4);
        bus.awlen   = 8'(len);
        #1;
        while (!bus.awready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("awready_wait", {31'd0, bus.awready}, 32'd1);
        @(negedge clk);
        bus.awvalid = 1'b0;
    endtask

    task automatic w_beats(input int word, input int len, input logic [31:0] base, input logic [3:0] strb);
        logic [31:0] d;
        int          n;
        chk("wready_after_aw", {31'd0, bus.wready}, 32'd1);
        for (int i = 0; i <= len; i++) begin
            n = 0;
            d = base + 32'(i);
            bus.wvalid = 1'b1;
            bus.wdata  = d;
            bus.wstrb  = strb;
            bus.wlast  = (i == len);
            #1;
            while (!bus.wready && n < 50) begin
                @(negedge clk);
                #1;
                n++;
            end
            chk("wready_wait", {31'd0, bus.wready}, 32'd1);
            chk("arready_low_in_write", {31'd0, bus.arready}, 32'd0);
            @(negedge clk);
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) model[(word + i) % 1024][b*8 +: 8] = d[b*8 +: 8];
            end
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        chk("awready_after_write", {31'd0, bus.awready}, 32'd1);
    endtask

    task automatic ar_req(input int word, input int len);
        int n;
        n = 0;
        for (int i = 0; i <= len; i++) begin
            sb_q.push_back('{model[(word + i) % 1024], (i == len)});
        end
        bus.arvalid = 1'b1;
        bus.araddr  = 32'(word * 4);
        bus.arlen   = 8'(len);
        #1;
        while (!bus.arready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("arready_wait", {31'd0, bus.arready}, 32'd1);
        @(negedge clk);
        bus.arvalid = 1'b0;
    endtask

    // mode 0: rready held high; mode 1: rready pattern 1,0,0,1,0,0...
    task automatic r_collect(input int nbeats, input int mode, input bit full);
        int beats;
        int cyc;
        beats = 0;
        cyc   = 0;
        chk("rvalid_first", {31'd0, bus.rvalid}, 32'd1);
        while (beats < nbeats && cyc < 200) begin
            bus.rready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            #1;
            if (!bus.rvalid || sb_q.size() == 0) begin
                chk("rvalid_mid_burst", {31'd0, bus.rvalid}, 32'd1);
                chk("scoreboard_depth", 32'(sb_q.size()), 32'd1);
                break;
            end else begin
                chk("rdata", bus.rdata, sb_q[0].data);
                chk("rlast", {31'd0, bus.rlast}, {31'd0, sb_q[0].last});
                if (bus.rready) begin
                    void'(sb_q.pop_front());
                    beats++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        bus.rready = 1'b0;
        chk("read_beats", 32'(beats), 32'(nbeats));
        if (full) begin
            if (mode == 0) chk("read_cycles", 32'(cyc), 32'(nbeats));
            chk("rvalid_end", {31'd0, bus.rvalid}, 32'd0);
            chk("arready_after_read", {31'd0, bus.arready}, 32'd1);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.awvalid = 1'b0;
        bus.awaddr  = 32'd0;
        bus.awlen   = 8'd0;
        bus.wdata   = 32'd0;
        bus.wstrb   = 4'd0;
        bus.wlast   = 1'b0;
        bus.wvalid  = 1'b0;
        bus.arvalid = 1'b0;
        bus.araddr  = 32'd0;
        bus.arlen   = 8'd0;
        bus.rready  = 1'b0;
        for (int i = 0; i < 1024; i++) model[i] = 32'd0;

        repeat (3) @(negedge clk);
        chk("reset_rvalid", {31'd0, bus.rvalid}, 32'd0);
        chk("reset_rlast", {31'd0, bus.rlast}, 32'd0);
        chk("reset_rdata", bus.rdata, 32'd0);
        chk("reset_awready", {31'd0, bus.awready}, 32'd1);
        chk("reset_wready", {31'd0, bus.wready}, 32'd0);
`ifdef BURST_MEMORY_SLAVE_ERR_EN
        chk("reset_err", {31'd0, err}, 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // 16-beat write of 0..15 then full-rate readback
        aw_req(0, 15);
        w_beats(0, 15, 32'd0, 4'hF);
        ar_req(0, 15);
        r_collect(16, 0, 1'b1);

        // Simultaneous requests: the write wins, the read waits for it
        bus.arvalid = 1'b1;
        bus.araddr  = 32'(100 * 4);
        bus.arlen   = 8'd3;
        bus.awvalid = 1'b1;
        bus.awaddr  = 32'(100 * 4);
        bus.awlen   = 8'd3;
        #1;
        chk("both_req_awready", {31'd0, bus.awready}, 32'd1);
        chk("both_req_arready", {31'd0, bus.arready}, 32'd0);
        aw_req(100, 3);
        w_beats(100, 3, 32'h1000_0000, 4'hF);
        ar_req(100, 3);
        r_collect(4, 0, 1'b1);

        // Stalled read with a 1,0,0 rready pattern
        ar_req(0, 15);
        r_collect(16, 1, 1'b1);

        // Byte-strobe merge into word 4
        aw_req(4, 0);
        w_beats(4, 0, 32'hAABB_CCDD, 4'hF);
        aw_req(4, 0);
        w_beats(4, 0, 32'h0000_00EE, 4'h1);
        ar_req(4, 0);
        r_collect(1, 0, 1'b1);

        // Burst wrapping past the last word
        aw_req(1022, 3);
        w_beats(1022, 3, 32'h5000_0000, 4'hF);
        ar_req(1022, 3);
        r_collect(4, 0, 1'b1);
`ifdef BURST_MEMORY_SLAVE_ERR_EN
        chk("err_after_wrap", {31'd0, err}, 32'd1);
`endif

        // Reset during beat 5 of a 16-beat read
        ar_req(0, 15);
        r_collect(5, 0, 1'b0);
        rst_n      = 1'b0;
        bus.rready = 1'b1;
        @(negedge clk);
        chk("midrst_rvalid", {31'd0, bus.rvalid}, 32'd0);
        chk("midrst_rlast", {31'd0, bus.rlast}, 32'd0);
        chk("midrst_rdata", bus.rdata, 32'd0);
`ifdef BURST_MEMORY_SLAVE_ERR_EN
        chk("midrst_err", {31'd0, err}, 32'd0);
`endif
        rst_n      = 1'b1;
        bus.rready = 1'b0;
        sb_q.delete();
        @(negedge clk);
        chk("post_rst_arready", {31'd0, bus.arready}, 32'd1);
        chk("post_rst_awready", {31'd0, bus.awready}, 32'd1);
        ar_req(3, 2);
        r_collect(3, 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
